conv3x3_stream_layer: RTL
=========================

# conv3x3_stream_layer

Streaming 3x3 convolution stage that sits directly upstream of the max-pool layer and produces the feature map it down-samples. It accepts one raster-scanned pixel per cycle over a valid/ready handshake, keeps two line buffers plus a 3x3 window register, and emits one fixed-point output pixel for every valid (no-padding) window position. Weights and bias are latched between frames.

## Interface
- WIDTH, 16: signed fixed-point word width of pixels, weights, bias and outputs.
- FRAC_BITS, 8: fractional bits (Q8.8 by default).
- INPUT_DIM_WIDTH, 34: input columns; minimum 3.
- INPUT_DIM_HEIGHT, 34: input rows; minimum 3.
- OUTPUT_DIM_WIDTH, INPUT_DIM_WIDTH-2: output columns (derived, not overridden).
- OUTPUT_DIM_HEIGHT, INPUT_DIM_HEIGHT-2: output rows (derived, not overridden).

- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- weight_in  input  WIDTH x [0:2][0:2] signed  kernel, row-major, [kr][kc].
- bias_in  input  WIDTH signed  bias.
- weight_load  input  1  latch weight_in/bias_in; honoured only in IDLE.
- in_valid  input  1  in_pixel valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_pixel  input  WIDTH signed  raster-order pixel, row 0 col 0 first.
- out_valid  output  1  out_pixel valid.
- out_ready  input  1  consumer accepts out_pixel.
- out_pixel  output  WIDTH signed  convolution result.
- out_last  output  1  high with the final output pixel (row OUTPUT_DIM_HEIGHT-1, col OUTPUT_DIM_WIDTH-1).
- frame_done  output  1  one-cycle pulse after the last output handshakes.

## Operation
- States: IDLE, ACTIVE, FLUSH.
  - IDLE: in_ready = !out_valid || out_ready; first accepted pixel -> ACTIVE. weight_load in IDLE captures weights/bias at that edge; if it coincides with the first pixel, the new weights apply to that frame.
  - ACTIVE: accepts pixels; on accepting pixel (H-1, W-1) -> FLUSH. weight_load ignored.
  - FLUSH: in_ready = 0; on final output handshake -> IDLE, frame_done = 1 the next cycle.
- Counters row (0..H-1), col (0..W-1) advance on each accepted pixel; col wraps to 0 and row increments at W-1; both clear on frame end.
- Line buffers: two WIDTH x INPUT_DIM_WIDTH rows hold input rows r-1 and r-2; window shifts left by one column on each accept.
- Output (r,c) = sum over kr,kc of in[r+kr][c+kc]*w[kr][kc] + bias; it is produced when pixel (r+2, c+2) is accepted. Pixels with row<2 or col<2 produce no output.
- Arithmetic: products are 2*WIDTH signed; the accumulator is 2*WIDTH+4 signed; bias is sign-extended and shifted left by FRAC_BITS before the add. The sum is arithmetically shifted right by FRAC_BITS (floor), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Backpressure: a single output register. A pixel is accepted only when in_valid && in_ready. out_pixel/out_valid/out_last hold stable while out_valid && !out_ready.
- Reset values: state IDLE, counters 0, out_valid 0, out_pixel 0, out_last 0, frame_done 0, weights/bias 0, line buffers 0. in_ready is 1 out of reset.
- Reset mid-frame: all of the above is restored immediately. Partial frame is discarded and the next pixel is treated as (0,0).

## Timing
- Latency: out_valid rises the cycle after the window-completing pixel is accepted (1 cycle).
- Throughput: 1 pixel/cycle with out_ready held high. A full frame takes H*W accept cycles plus 1 cycle to the last output.
- Simultaneous output handshake and new window-completing pixel in the same cycle: the register reloads, and out_valid stays high with no bubble.
- frame_done is asserted exactly one cycle, on the cycle after the out_last handshake; in_ready returns the same cycle as frame_done.

## Configuration
- CONV3X3_RELU_OUTPUT_EN defined: ReLU is applied after saturation, so negative results become 0 and outputs are guaranteed non-negative for the max-pool stage.
- Not defined: the saturated signed result passes through unchanged.

## Test plan
- Identity kernel (center=256, others 0, bias 0), 5x5 input in[r][c]=256*(5r+c) -> 9 outputs equal in[r+1][c+1]; out_last on the 9th; frame_done one cycle later.
- All-ones kernel (256), all inputs 256, bias 128 -> every output 2432 (9.5 in Q8.8).
- Saturation: all weights 32767, all inputs 32767 -> out_pixel 32767. All weights -32768, all inputs 32767 -> -32768, or 0 with CONV3X3_RELU_OUTPUT_EN.
- Backpressure: hold out_ready low for 5 cycles with a pending output -> in_ready low, out_pixel stable, and no pixel lost. Output sequence matches the no-stall run.
- weight_load pulsed in ACTIVE with new kernel -> current frame uses old weights; a load in the following IDLE takes effect on the next frame.
- Assert rst after 12 pixels of a 5x5 frame -> outputs cleared, state IDLE. Next full frame yields correct results with no residue from the aborted frame.

Source files
------------

// File: rtl/conv3x3_stream_layer.sv
// Streaming 3x3 no-padding convolution with two line buffers and a single output register.
// Optional macro CONV3X3_RELU_OUTPUT_EN clamps negative results to zero after saturation.
module conv3x3_stream_layer #(
  parameter int WIDTH            = 16,
  parameter int FRAC_BITS        = 8,
  parameter int INPUT_DIM_WIDTH  = 34,
  parameter int INPUT_DIM_HEIGHT = 34,
  localparam int OUTPUT_DIM_WIDTH  = INPUT_DIM_WIDTH - 2,
  localparam int OUTPUT_DIM_HEIGHT = INPUT_DIM_HEIGHT - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] weight_in [0:2][0:2],
  input  logic signed [WIDTH-1:0] bias_in,
  input  logic                    weight_load,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_pixel,
  output logic                    out_last,
  output logic                    frame_done
);

  localparam int COL_W = $clog2(INPUT_DIM_WIDTH);
  localparam int ROW_W = $clog2(INPUT_DIM_HEIGHT);
  localparam int PW    = 2 * WIDTH;
  localparam int AW    = 2 * WIDTH + 4;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t                  state;
  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic signed [WIDTH-1:0] w_q [0:2][0:2];
  logic signed [WIDTH-1:0] bias_q;
  logic signed [WIDTH-1:0] lb1 [INPUT_DIM_WIDTH];
  logic signed [WIDTH-1:0] lb2 [INPUT_DIM_WIDTH];
  logic signed [WIDTH-1:0] win [0:2][0:2];
  logic signed [WIDTH-1:0] nw  [0:2][0:2];
  logic signed [AW-1:0]    acc, shifted, sat;
  logic signed [WIDTH-1:0] result;
  logic                    accept, out_fire, win_done, last_pix;

  assign in_ready = (state != FLUSH) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign win_done = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign last_pix = (row == ROW_W'(OUTPUT_DIM_HEIGHT + 1)) && (col == COL_W'(OUTPUT_DIM_WIDTH + 1));

  // Window as it will look after this accept: the new column is rows r-2, r-1, r at col.
  // NOTE: every always_comb target is fully assigned on every path, so no latch can form.
  always_comb begin
    for (int kr = 0; kr < 3; kr++) begin
      nw[kr][0] = win[kr][1];
      nw[kr][1] = win[kr][2];
    end
    nw[0][2] = lb2[col];
    nw[1][2] = lb1[col];
    nw[2][2] = in_pixel;

    acc = AW'(bias_q) <<< FRAC_BITS;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        acc = acc + AW'(PW'(nw[kr][kc]) * PW'(w_q[kr][kc]));

    shifted = acc >>> FRAC_BITS;
    if (shifted > SAT_MAX)      sat = SAT_MAX;
    else if (shifted < SAT_MIN) sat = SAT_MIN;
    else                        sat = shifted;
`ifdef CONV3X3_RELU_OUTPUT_EN
    result = (sat < 0) ? '0 : sat[WIDTH-1:0];
`else
    result = sat[WIDTH-1:0];
`endif
  end

  // NOTE: line buffers are reset explicitly so an aborted frame leaves no residue behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INPUT_DIM_WIDTH; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
      for (int kr = 0; kr < 3; kr++)
        for (int kc = 0; kc < 3; kc++)
          win[kr][kc] <= '0;
    end else if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= in_pixel;
      win      <= nw;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      bias_q     <= '0;
      for (int kr = 0; kr < 3; kr++)
        for (int kc = 0; kc < 3; kc++)
          w_q[kr][kc] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE && weight_load) begin
        w_q    <= weight_in;
        bias_q <= bias_in;
      end

      if (accept) begin
        if (col == COL_W'(INPUT_DIM_WIDTH - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(INPUT_DIM_HEIGHT - 1)) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      // Accept implies the register is free or draining this cycle, so reload wins.
      if (accept && win_done) begin
        out_pixel <= result;
        out_valid <= 1'b1;
        out_last  <= last_pix;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        IDLE:    if (accept) state <= ACTIVE;
        ACTIVE:  if (accept && last_pix) state <= FLUSH;
        FLUSH:   if (out_fire && out_last) begin
                   state      <= IDLE;
                   frame_done <= 1'b1;
                 end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
